mtsp_memcmd_arbiter: RTL

MTSP_MEMCMD_ARBITER -- requirements
Module: mtsp_memcmd_arbiter

---
 rtl/mtsp_memcmd_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/mtsp_memcmd_arbiter.sv
// Round-robin arbiter that turns per-core memory requests into one latched
// command at a time: select, issue, wait for the memory, then acknowledge.
module mtsp_memcmd_arbiter #(
  parameter int CORE_SIZE = 4,
  parameter int ID_W      = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CORE_SIZE-1:0]   REQ,
  input  logic [CORE_SIZE-1:0]   REQ_WRITE,
  input  logic [CORE_SIZE*32-1:0] REQ_ADDR,
  input  logic [CORE_SIZE*8-1:0] REQ_SIZE,
  output logic [CORE_SIZE-1:0]   DONE,
  output logic                   CMD_VALID,
  input  logic                   CMD_READY,
  output logic                   CMD_WRITE,
  output logic [31:0]            CMD_ADDR,
  output logic [7:0]             CMD_SIZE,
  output logic [ID_W-1:0]        CMD_ID,
  input  logic                   MEM_BUSY,
  output logic                   BUSY,
  output logic [1:0]             dbg_state,
  output logic [ID_W-1:0]        dbg_ptr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  logic [1:0]      state;
  logic [ID_W-1:0] ptr;
  logic            wait_first;

  logic            found;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] ptr_next;

  // Scan from ptr upward, wrapping at CORE_SIZE; the first asserted request wins.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_w;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int i = 0; i < CORE_SIZE; i++) begin
      idx = int'(ptr) + i;
      if (idx >= CORE_SIZE) idx = idx - CORE_SIZE;
      idx_w = ID_W'(idx);
      if (!found && REQ[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  assign ptr_next = (winner == ID_W'(CORE_SIZE - 1)) ? '0 : winner + ID_W'(1);

  // Handshake: CMD_VALID is high only in ISSUE, where the CMD_* fields are held
  // constant; the command is transferred on the rising edge where
  // CMD_VALID && CMD_READY, and CMD_VALID never drops before that edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      ptr        <= '0;
      wait_first <= 1'b0;
      CMD_WRITE  <= 1'b0;
      CMD_ADDR   <= '0;
      CMD_SIZE   <= '0;
      CMD_ID     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            CMD_WRITE <= REQ_WRITE[winner];
            CMD_ADDR  <= REQ_ADDR[winner*32 +: 32];
            CMD_SIZE  <= REQ_SIZE[winner*8 +: 8];
            CMD_ID    <= winner;
            ptr       <= ptr_next;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (CMD_READY) begin
            state      <= WAIT;
            wait_first <= 1'b1;
          end
        end
        WAIT: begin
          // MEM_BUSY may not yet reflect the just-accepted command, so skip one cycle.
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!MEM_BUSY) begin
            state <= ACK;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    DONE = '0;
    if (state == ACK) DONE[CMD_ID] = 1'b1;
  end

  assign CMD_VALID = (state == ISSUE);
  assign BUSY      = (state != IDLE);
  assign dbg_state = state;
  assign dbg_ptr   = ptr;

endmodule
